// File: rtl/onehot_step_sequencer.sv
// onehot_step_sequencer
//   Registered binary-to-one-hot timing generator for the CPU control unit.
//   Holds a binary step index (0 = idle) and drives one-hot step strobes
//   T1..TSTEPS. It supports start, advance, jump (load), a per-instruction
//   sequence length, a completion pulse and a sticky out-of-range error.
//
// Parameters
//   WIDTH      width of the binary step index
//   STEPS      number of one-hot strobes (1 <= STEPS <= 2^WIDTH - 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a sequence at step 1 (honoured only when idle)
//   advance    step to the next index (honoured only when busy)
//   clear      abort to idle and clear err
//   load       jump to load_idx
//   load_idx   jump target; values above STEPS set err and leave idx alone
//   last_step  final step of the current sequence; 0 or >STEPS means STEPS
//   idx        current binary step index
//   onehot     bit k-1 high iff idx == k
//   busy       high iff idx != 0
//   done       one-cycle pulse when a sequence completes through advance
//   err        sticky out-of-range load flag
module onehot_step_sequencer #(
  parameter int WIDTH = 5,
  parameter int STEPS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_idx,
  input  logic [WIDTH-1:0] last_step,
  output logic [WIDTH-1:0] idx,
  output logic [STEPS-1:0] onehot,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] STEPS_IDX = WIDTH'(STEPS);

  // The single action selected this cycle, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_LOAD_ERR,
    ACT_START,
    ACT_STEP,
    ACT_FINISH
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] eff_last;
  logic [WIDTH-1:0] idx_next;
  logic [STEPS-1:0] onehot_next;
  logic             busy_next;
  logic             done_next;
  logic             err_next;

  always_comb begin
    eff_last = STEPS_IDX;
    if (last_step != '0 && last_step <= STEPS_IDX) begin
      eff_last = last_step;
    end

    // A start while busy is ignored rather than consuming the cycle, so an
    // advance asserted alongside it still takes effect.
    action = ACT_HOLD;
    if (clear) begin
      action = ACT_CLEAR;
    end else if (load) begin
      action = (load_idx <= STEPS_IDX) ? ACT_LOAD : ACT_LOAD_ERR;
    end else if (start && idx == '0) begin
      action = ACT_START;
    end else if (advance && idx != '0) begin
      // Completing at STEPS as well as at eff_last keeps an index that sits
      // beyond eff_last from ever wrapping past the last strobe.
      action = (idx == eff_last || idx == STEPS_IDX) ? ACT_FINISH : ACT_STEP;
    end
  end

  always_comb begin
    idx_next  = idx;
    err_next  = err;
    done_next = 1'b0;
    unique case (action)
      ACT_CLEAR: begin
        idx_next = '0;
        err_next = 1'b0;
      end
      ACT_LOAD:     idx_next = load_idx;
      ACT_LOAD_ERR: err_next = 1'b1;
      ACT_START:    idx_next = WIDTH'(1);
      ACT_STEP:     idx_next = idx + WIDTH'(1);
      ACT_FINISH: begin
        idx_next  = '0;
        done_next = 1'b1;
      end
      default: ;
    endcase

    onehot_next = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      onehot_next[k] = (idx_next == WIDTH'(k + 1));
    end
    busy_next = (idx_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      onehot <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      idx    <= idx_next;
      onehot <= onehot_next;
      busy   <= busy_next;
      done   <= done_next;
      err    <= err_next;
    end
  end

endmodule

// File: tb/tb_onehot_step_sequencer.sv
// Testbench for onehot_step_sequencer: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a
// behavioural model of the step index, done pulse and error flag.
module tb_onehot_step_sequencer;

  localparam int WIDTH = 5;
  localparam int STEPS = 20;

  logic             clk = 1'b0;
  logic             rst, start, advance, clear, load;
  logic [WIDTH-1:0] load_idx, last_step;
  logic [WIDTH-1:0] idx;
  logic [STEPS-1:0] onehot;
  logic             busy, done, err;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_idx  = 0;
  bit m_err  = 1'b0;
  bit m_done = 1'b0;
  bit m_valid = 1'b0;

  onehot_step_sequencer #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .advance   (advance),
    .clear     (clear),
    .load      (load),
    .load_idx  (load_idx),
    .last_step (last_step),
    .idx       (idx),
    .onehot    (onehot),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the spec's priority rules applied to an integer index.
  always @(posedge clk) begin
    int eff;
    if (rst) begin
      m_idx = 0; m_err = 1'b0; m_done = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      eff = (int'(last_step) >= 1 && int'(last_step) <= STEPS) ? int'(last_step) : STEPS;
      if (clear) begin
        m_idx = 0; m_err = 1'b0;
      end else if (load) begin
        if (int'(load_idx) <= STEPS) m_idx = int'(load_idx);
        else m_err = 1'b1;
      end else if (start && m_idx == 0) begin
        m_idx = 1;
      end else if (advance && m_idx != 0) begin
        if (m_idx == eff || m_idx == STEPS) begin
          m_idx = 0; m_done = 1'b1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
  end

  // Single compare process: DUT vs model on every cycle after reset is seen.
  always @(negedge clk) begin
    logic [STEPS-1:0] e_oh;
    if (m_valid) begin
      e_oh = '0;
      if (m_idx > 0) e_oh[m_idx-1] = 1'b1;
      chk("model_idx",    32'(idx),    32'(m_idx));
      chk("model_onehot", 32'(onehot), 32'(e_oh));
      chk("model_busy",   32'(busy),   32'(m_idx != 0));
      chk("model_done",   32'(done),   32'(m_done));
      chk("model_err",    32'(err),    32'(m_err));
      chk("inv_busy",     32'(busy),   32'(|onehot));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; advance = 1'b0; clear = 1'b0; load = 1'b0;
    load_idx = '0;
  endtask

  initial begin
    idle_inputs();
    last_step = '0;

    // Reset with start/advance held
    rst = 1'b1; start = 1'b1; advance = 1'b1;
    cyc(); cyc();
    chk("rst_idx", 32'(idx), 0);
    chk("rst_onehot", 32'(onehot), 32'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    idle_inputs();
    cyc();
    chk("post_rst_idx", 32'(idx), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Full sequence with last_step=4
    last_step = 5'd4; start = 1'b1;
    cyc();
    chk("seq4_t1", 32'(onehot), 32'h1);
    start = 1'b0; advance = 1'b1;
    cyc(); chk("seq4_t2", 32'(onehot), 32'h2);
    cyc(); chk("seq4_t3", 32'(onehot), 32'h4);
    cyc(); chk("seq4_t4", 32'(onehot), 32'h8);
    cyc();
    chk("seq4_end_idx", 32'(idx), 0);
    chk("seq4_done", 32'(done), 1);
    advance = 1'b0;
    cyc();
    chk("seq4_done_low", 32'(done), 0);

    // Default length
    last_step = '0; start = 1'b1;
    cyc(); chk("def_idx1", 32'(idx), 1);
    start = 1'b0; advance = 1'b1;
    for (int k = 2; k <= STEPS; k++) begin
      cyc(); chk("def_idx", 32'(idx), 32'(k));
    end
    chk("def_onehot20", 32'(onehot), 32'h80000);
    cyc();
    chk("def_end_idx", 32'(idx), 0);
    chk("def_done", 32'(done), 1);
    advance = 1'b0;

    // Load and error
    start = 1'b1; cyc(); start = 1'b0;
    advance = 1'b1; cyc(); cyc(); advance = 1'b0;
    chk("ld_pre_idx", 32'(idx), 3);
    load = 1'b1; load_idx = 5'd10;
    cyc();
    chk("ld_idx", 32'(idx), 10);
    chk("ld_onehot", 32'(onehot), 32'h00200);
    load_idx = 5'd25;
    cyc();
    chk("ld_bad_idx", 32'(idx), 10);
    chk("ld_bad_err", 32'(err), 1);
    load = 1'b0; advance = 1'b1;
    cyc(); chk("err_hold1", 32'(err), 1); chk("ld_adv_idx", 32'(idx), 11);
    cyc(); chk("err_hold2", 32'(err), 1);
    advance = 1'b0; clear = 1'b1;
    cyc();
    chk("clr_idx", 32'(idx), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_done", 32'(done), 0);
    clear = 1'b0;

    // Priority
    start = 1'b1; cyc(); start = 1'b0;
    advance = 1'b1; repeat (4) cyc();
    chk("pri_pre_idx", 32'(idx), 5);
    clear = 1'b1; load = 1'b1; load_idx = 5'd7;
    cyc();
    chk("pri_clr_idx", 32'(idx), 0);
    chk("pri_clr_done", 32'(done), 0);
    clear = 1'b0; advance = 1'b0; load_idx = 5'd2; start = 1'b1;
    cyc();
    chk("pri_ld_start", 32'(idx), 2);
    load = 1'b0; start = 1'b0;

    // Ignored requests
    advance = 1'b1; repeat (4) cyc(); advance = 1'b0;
    chk("ign_pre_idx", 32'(idx), 6);
    start = 1'b1;
    cyc(); chk("ign_start", 32'(idx), 6);
    advance = 1'b1;
    cyc(); chk("ign_start_adv", 32'(idx), 7);
    start = 1'b0; advance = 1'b0; clear = 1'b1;
    cyc(); clear = 1'b0;
    advance = 1'b1;
    cyc();
    chk("ign_adv_idx", 32'(idx), 0);
    chk("ign_adv_done", 32'(done), 0);

    // Continuous start+advance: one idle cycle per instruction
    last_step = 5'd3; start = 1'b1; advance = 1'b1;
    cyc(); chk("cont_1", 32'(idx), 1);
    cyc(); chk("cont_2", 32'(idx), 2);
    cyc(); chk("cont_3", 32'(idx), 3);
    cyc(); chk("cont_0", 32'(idx), 0); chk("cont_done", 32'(done), 1);
    cyc(); chk("cont_restart", 32'(idx), 1);

    // Shrinking last_step below idx: runs on to STEPS then completes
    start = 1'b0; last_step = 5'd20;
    repeat (8) cyc();
    chk("shrink_pre", 32'(idx), 9);
    last_step = 5'd4;
    repeat (11) cyc();
    chk("shrink_at20", 32'(idx), 20);
    cyc();
    chk("shrink_end", 32'(idx), 0);
    chk("shrink_done", 32'(done), 1);
    advance = 1'b0;

    // Randomized stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_idx = WIDTH'($urandom_range(0, 31));
      start    = ($urandom_range(0, 3) == 0);
      advance  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) last_step = WIDTH'($urandom_range(0, 31));
      cyc();
    end

    idle_inputs();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_step_sequencer.md
# onehot_step_sequencer

Parametrised, registered binary-to-one-hot timing generator for the CPU control unit. It holds a binary step index and drives one-hot step strobes T1..TSTEPS; index 0 is the idle state with all strobes low. It adds start, advance, jump (load), per-instruction sequence length, a done pulse and an error flag. It sits between the instruction decoder, which supplies control, and the datapath enables, which consume the strobes.

## Interface
- WIDTH, 5, width of the binary step index.
- STEPS, 20, number of one-hot strobes; must satisfy 1 <= STEPS <= 2^WIDTH - 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence at step 1; honoured only when idle.
- advance  input  1  step to the next index; honoured only when busy.
- clear  input  1  abort to idle; also clears err.
- load  input  1  jump to load_idx.
- load_idx  input  WIDTH  target index for load.
- last_step  input  WIDTH  final step of the current sequence; 0 or >STEPS means STEPS.
- idx  output  WIDTH  current binary step index.
- onehot  output  STEPS  bit k-1 is high iff idx == k, for k = 1..STEPS; all zero when idx == 0.
- busy  output  1  high iff idx != 0.
- done  output  1  one-cycle pulse on the cycle idx returns to 0 through sequence completion.
- err  output  1  sticky flag set by an out-of-range load.

## Operation
- Fixed priority per edge: rst > clear > load > start > advance. At most one action per cycle; lower-priority inputs are ignored that cycle.
- rst: idx=0, onehot=0, busy=0, done=0, err=0.
- clear: idx=0, onehot=0, err=0, done=0. Clear does not pulse done.
- load with load_idx <= STEPS: idx=load_idx, one-hot updated to match; load_idx=0 goes idle without done. Legal from idle or busy.
- load with load_idx > STEPS: idx unchanged, err set to 1. err stays 1 until rst or clear.
- start when idx==0: idx=1. start when busy: ignored, no error.
- advance when busy:
  - If idx == effective last (eff_last = last_step if 1..STEPS, else STEPS): idx=0 and done=1 on the same edge.
  - Otherwise idx=idx+1.
- advance when idle: ignored.
- last_step is sampled on every advance, not latched at start. Changing it mid-sequence takes effect at the next advance.
- If idx > eff_last, which can only happen after a load or a last_step change, advance increments until idx==STEPS. It then completes at STEPS: idx=0, done=1. The index never wraps past STEPS.
- done is low in every cycle not directly following a completing advance.
- Invariant checked every cycle: onehot == (idx==0 ? 0 : 1<<(idx-1)), and busy == |onehot.

## Timing
- All outputs are registered. An input sampled at edge n is reflected in idx, onehot, busy, done and err after edge n.
- Latency is 1 cycle from start to T1. A sequence with eff_last=L occupies L busy cycles when advance is held high.
- Holding start and advance both high continuously:
  - start at edge 0 gives idx=1.
  - Advances run to L.
  - The completing advance gives idx=0 with done=1.
  - The next edge restarts at idx=1, so there is exactly one idle cycle per instruction.
- Reset mid-sequence takes effect at the next edge regardless of other inputs. There is no partial step.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert rst for 2 cycles with start=1 and advance=1 → idx=0, onehot=20'h0, busy=0, done=0, err=0. Release rst with inputs low → outputs remain at 0.
- Full sequence: last_step=4, pulse start, then hold advance → onehot reads 1, 2, 4, 8 on successive cycles. Then idx=0 with done=1 for exactly one cycle, then done=0.
- Default length: last_step=0, start, hold advance → idx counts 1..20 and onehot ends at 20'h80000. The next edge gives idx=0 with done=1; idx never reaches 21.
- Load and error: busy at idx=3, load=1 with load_idx=10 → idx=10, onehot=20'h00200. Then load_idx=25 → idx stays 10 and err=1. err stays 1 through further advances; clear → idx=0 and err=0.
- Priority: at idx=5 assert clear, load (load_idx=7) and advance together → idx=0, done=0. From idle assert load (load_idx=2) and start together → idx=2.
- Ignored requests: start while idx=6 → idx=7 only if advance is also high, otherwise it stays 6. advance while idle → idx stays 0 and done stays 0.
